// File: rtl/word_op_pkg.sv
// Shared constants and helpers for the word_op_unit Booth operand slice.
// The WORD_OP_OVF_EN macro (used in word_op_unit) adds the out_ovf flag.
package word_op_pkg;

  localparam logic [1:0] MODE_PASS   = 2'd0;
  localparam logic [1:0] MODE_TOGGLE = 2'd1;
  localparam logic [1:0] MODE_NEGATE = 2'd2;
  localparam logic [1:0] MODE_DOUBLE = 2'd3;

  typedef enum logic [2:0] {
    WAIT = 3'd0,
    CALC = 3'd1,
    FIN  = 3'd2
  } state_e;

  function automatic int unsigned calc_nchunk(input int unsigned bitlen,
                                              input int unsigned chunk);
    return bitlen / chunk;
  endfunction

  // Counter needs at least one bit even when the whole word is a single chunk.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/word_op_chunk.sv
// Combinational CHUNK-wide slice of the operand unit; the chain bit links
// consecutive chunks (carry for NEGATE, shifted-out bit for DOUBLE).
module word_op_chunk
  import word_op_pkg::*;
#(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_x,
  input  logic [1:0]       i_mode,
  input  logic             i_c,
  output logic [CHUNK-1:0] o_r,
  output logic             o_c
);

  logic [CHUNK:0]   w_sum;
  logic [CHUNK-1:0] w_dbl;

  assign w_sum = {1'b0, ~i_x} + {{CHUNK{1'b0}}, i_c};

  generate
    if (CHUNK == 1) begin : g_dbl_one
      assign w_dbl = i_c;
    end else begin : g_dbl_wide
      assign w_dbl = {i_x[CHUNK-2:0], i_c};
    end
  endgenerate

  always_comb begin
    o_r = i_x;
    o_c = 1'b0;
    case (i_mode)
      MODE_PASS: begin
        o_r = i_x;
      end
      MODE_TOGGLE: begin
        o_r = ~i_x;
      end
      MODE_NEGATE: begin
        o_r = w_sum[CHUNK-1:0];
        o_c = w_sum[CHUNK];
      end
      MODE_DOUBLE: begin
        o_r = w_dbl;
        o_c = i_x[CHUNK-1];
      end
      default: begin
        o_r = i_x;
      end
    endcase
  end

endmodule

// File: rtl/word_op_unit.sv
// Multi-mode Booth operand unit: PASS/TOGGLE/NEGATE/DOUBLE, CHUNK bits per cycle.
// Define WORD_OP_OVF_EN to add the out_ovf port and its overflow logic.
module word_op_unit
  import word_op_pkg::*;
#(
  parameter int unsigned BITLEN = 8,
  parameter int unsigned CHUNK  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [BITLEN-1:0] in_word,
  input  logic [1:0]        in_mode,
  input  logic              in_valid_pulse,
  output logic              mod_busy,
  output logic [BITLEN-1:0] out_word,
  output logic              out_valid_pulse
`ifdef WORD_OP_OVF_EN
  ,
  output logic              out_ovf
`endif
);

  localparam int unsigned NCHUNK = calc_nchunk(BITLEN, CHUNK);
  localparam int unsigned CW     = cnt_width(NCHUNK);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  generate
    if (BITLEN < 2 || (BITLEN % CHUNK) != 0) begin : g_bad_cfg
      $error("word_op_unit: BITLEN must be >= 2 and a multiple of CHUNK");
    end
  endgenerate

  state_e            r_state;
  state_e            w_state_next;
  logic              w_accept;
  logic              w_step;
  logic              w_finish;
  logic              w_recover;

  logic [BITLEN-1:0] r_op;
  logic [BITLEN-1:0] r_acc;
  logic [1:0]        r_mode;
  logic              r_chain;
  logic [CW-1:0]     r_cnt;

  logic [CHUNK-1:0]  w_r;
  logic              w_c;
  logic [BITLEN-1:0] w_acc_next;

  word_op_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .i_x    (r_op[CHUNK-1:0]),
    .i_mode (r_mode),
    .i_c    (r_chain),
    .o_r    (w_r),
    .o_c    (w_c)
  );

  // Result chunks enter at the top and drift down, LSB chunk ends lowest.
  assign w_acc_next = BITLEN'({w_r, r_acc} >> CHUNK);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= WAIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_step       = 1'b0;
    w_finish     = 1'b0;
    w_recover    = 1'b0;
    case (r_state)
      WAIT: begin
        if (in_valid_pulse) begin
          w_accept     = 1'b1;
          w_state_next = CALC;
        end
      end
      CALC: begin
        w_step = 1'b1;
        if (r_cnt == LAST) begin
          w_state_next = FIN;
        end
      end
      FIN: begin
        w_finish     = 1'b1;
        w_state_next = WAIT;
      end
      default: begin
        w_recover    = 1'b1;
        w_state_next = WAIT;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_op            <= '0;
      r_acc           <= '0;
      r_mode          <= MODE_PASS;
      r_chain         <= 1'b0;
      r_cnt           <= '0;
      mod_busy        <= 1'b0;
      out_word        <= '0;
      out_valid_pulse <= 1'b0;
    end else begin
      out_valid_pulse <= 1'b0;
      if (w_accept) begin
        r_op     <= in_word;
        r_mode   <= in_mode;
        r_chain  <= (in_mode == MODE_NEGATE);
        r_acc    <= '0;
        r_cnt    <= '0;
        mod_busy <= 1'b1;
      end
      if (w_step) begin
        r_op    <= r_op >> CHUNK;
        r_acc   <= w_acc_next;
        r_chain <= w_c;
        r_cnt   <= r_cnt + CW'(1);
      end
      if (w_finish) begin
        out_word        <= r_acc;
        out_valid_pulse <= 1'b1;
        mod_busy        <= 1'b0;
      end
      if (w_recover) begin
        mod_busy <= 1'b0;
      end
    end
  end

`ifdef WORD_OP_OVF_EN
  logic r_ovf_pend;
  logic w_ovf_calc;

  // Overflow depends only on the accepted operand, so it is resolved up front.
  always_comb begin
    w_ovf_calc = 1'b0;
    case (in_mode)
      MODE_NEGATE: w_ovf_calc = (in_word == {1'b1, {(BITLEN-1){1'b0}}});
      MODE_DOUBLE: w_ovf_calc = in_word[BITLEN-1] ^ in_word[BITLEN-2];
      default:     w_ovf_calc = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ovf_pend <= 1'b0;
      out_ovf    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ovf_pend <= w_ovf_calc;
      end
      if (w_finish) begin
        out_ovf <= r_ovf_pend;
      end
    end
  end
`endif

endmodule

// File: tb/tb_word_op_unit.sv
// Directed bench for word_op_unit at BITLEN=8 with CHUNK = 4, 1 and 8.
module tb_word_op_unit;
  import word_op_pkg::*;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] word;
    logic [7:0] res;
    logic       ovf;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [7:0] iw   [3];
  logic [1:0] im   [3];
  logic       iv   [3];
  logic       busy [3];
  logic [7:0] ow   [3];
  logic       ovp  [3];
  logic       ovf  [3];

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    word_op_unit #(
      .BITLEN (8),
      .CHUNK  (g == 0 ? 4 : (g == 1 ? 1 : 8))
    ) u_dut (
      .clock           (clk),
      .reset           (rst),
      .in_word         (iw[g]),
      .in_mode         (im[g]),
      .in_valid_pulse  (iv[g]),
      .mod_busy        (busy[g]),
      .out_word        (ow[g]),
      .out_valid_pulse (ovp[g])
`ifdef WORD_OP_OVF_EN
      ,
      .out_ovf         (ovf[g])
`endif
    );
`ifndef WORD_OP_OVF_EN
    assign ovf[g] = 1'b0;
`endif
  end

  function automatic int nch(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 8 : 1);
  endfunction

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0h expected %0h", name, k, act, exp);
    end
  endtask

  task automatic run_op(input int k, input vec_t v);
    @(negedge clk);
    iw[k] = v.word;
    im[k] = v.mode;
    iv[k] = 1'b1;
    @(negedge clk);
    iv[k] = 1'b0;
    iw[k] = ~v.word;
    im[k] = ~v.mode;
    check("busy_after_accept", k, busy[k], 1);
    for (int e = 1; e <= nch(k); e++) begin
      @(negedge clk);
      check("busy_in_calc", k, busy[k], 1);
      check("no_early_pulse", k, ovp[k], 0);
    end
    @(negedge clk);
    check("pulse_at_done", k, ovp[k], 1);
    check("busy_cleared", k, busy[k], 0);
    check("result", k, ow[k], v.res);
`ifdef WORD_OP_OVF_EN
    check("ovf", k, ovf[k], v.ovf);
`endif
    @(negedge clk);
    check("pulse_single", k, ovp[k], 0);
    check("result_hold", k, ow[k], v.res);
  endtask

  task automatic drop_test(input int k);
    int pulses;
    pulses = 0;
    @(negedge clk);
    iw[k] = 8'h05; im[k] = MODE_NEGATE; iv[k] = 1'b1;
    @(negedge clk);
    iw[k] = 8'h11; im[k] = MODE_PASS; iv[k] = 1'b1;
    @(negedge clk);
    iv[k] = 1'b0;
    for (int j = 0; j < nch(k) + 3; j++) begin
      @(negedge clk);
      if (ovp[k]) pulses++;
    end
    check("drop_pulse_count", k, pulses, 1);
    check("drop_result", k, ow[k], 8'hFB);
    check("drop_idle", k, busy[k], 0);
  endtask

  task automatic b2b_test(input int k);
    @(negedge clk);
    iw[k] = 8'h3C; im[k] = MODE_PASS; iv[k] = 1'b1;
    @(negedge clk);
    iv[k] = 1'b0;
    repeat (nch(k)) @(negedge clk);
    @(negedge clk);
    check("b2b_first_pulse", k, ovp[k], 1);
    check("b2b_first_result", k, ow[k], 8'h3C);
    iw[k] = 8'hA5; im[k] = MODE_TOGGLE; iv[k] = 1'b1;
    @(negedge clk);
    iv[k] = 1'b0;
    check("b2b_second_accepted", k, busy[k], 1);
    check("b2b_gap", k, ovp[k], 0);
    repeat (nch(k)) @(negedge clk);
    @(negedge clk);
    check("b2b_second_pulse", k, ovp[k], 1);
    check("b2b_second_result", k, ow[k], 8'h5A);
  endtask

  task automatic reset_mid_test(input int k);
    int pulses;
    pulses = 0;
    @(negedge clk);
    iw[k] = 8'h05; im[k] = MODE_NEGATE; iv[k] = 1'b1;
    @(negedge clk);
    iv[k] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", k, busy[k], 0);
    check("rst_mid_word", k, ow[k], 0);
    check("rst_mid_pulse", k, ovp[k], 0);
    for (int j = 0; j < nch(k) + 2; j++) begin
      @(negedge clk);
      if (ovp[k]) pulses++;
    end
    check("rst_mid_no_pulse", k, pulses, 0);
  endtask

  task automatic reset_dom_test(input int k);
    int pulses;
    pulses = 0;
    @(negedge clk);
    rst = 1'b1;
    iw[k] = 8'h21; im[k] = MODE_DOUBLE; iv[k] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    iv[k] = 1'b0;
    check("rst_dom_busy", k, busy[k], 0);
    for (int j = 0; j < nch(k) + 2; j++) begin
      @(negedge clk);
      if (ovp[k]) pulses++;
    end
    check("rst_dom_no_pulse", k, pulses, 0);
  endtask

  initial begin
    vec_t vecs[11];
    vecs[0]  = '{MODE_NEGATE, 8'h05, 8'hFB, 1'b0};
    vecs[1]  = '{MODE_NEGATE, 8'h00, 8'h00, 1'b0};
    vecs[2]  = '{MODE_NEGATE, 8'h80, 8'h80, 1'b1};
    vecs[3]  = '{MODE_NEGATE, 8'h10, 8'hF0, 1'b0};
    vecs[4]  = '{MODE_NEGATE, 8'hFF, 8'h01, 1'b0};
    vecs[5]  = '{MODE_TOGGLE, 8'hA5, 8'h5A, 1'b0};
    vecs[6]  = '{MODE_TOGGLE, 8'h00, 8'hFF, 1'b0};
    vecs[7]  = '{MODE_PASS,   8'h3C, 8'h3C, 1'b0};
    vecs[8]  = '{MODE_DOUBLE, 8'h47, 8'h8E, 1'b1};
    vecs[9]  = '{MODE_DOUBLE, 8'h21, 8'h42, 1'b0};
    vecs[10] = '{MODE_DOUBLE, 8'hC3, 8'h86, 1'b0};

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iw[k] = 8'h00;
      im[k] = 2'd0;
      iv[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("reset_busy", k, busy[k], 0);
      check("reset_word", k, ow[k], 0);
      check("reset_pulse", k, ovp[k], 0);
`ifdef WORD_OP_OVF_EN
      check("reset_ovf", k, ovf[k], 0);
`endif
    end
    rst = 1'b0;

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 11; i++) begin
        run_op(k, vecs[i]);
      end
      drop_test(k);
      b2b_test(k);
      reset_mid_test(k);
      reset_dom_test(k);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
